// File: rtl/tsn_axis_pkg.sv
// Shared definitions for the AXI4-Stream frame monitor: tuser field
// offsets, error flag bit positions, FSM state type and keep helpers.
package tsn_axis_pkg;

    // NetFPGA tuser layout
    localparam int LEN_LO      = 0;
    localparam int LEN_HI      = 15;
    localparam int DST_PORT_LO = 24;

    // err_flags bit positions, packed as {keep, port, range, len, mac}
    localparam int ERR_MAC   = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_RANGE = 2;
    localparam int ERR_PORT  = 3;
    localparam int ERR_KEEP  = 4;
    localparam int ERR_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_LAST = 2'd2
    } mon_state_t;

    // Number of set bits; keep vectors up to 64 lanes are zero-extended.
    function automatic logic [15:0] popcount64(input logic [63:0] v);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {15'd0, v[i]};
        end
        return c;
    endfunction

    // True when v is nonzero and of the form 0...01...1 (low lanes only).
    function automatic logic keep_contig_nz(input logic [63:0] v);
        return (v != 64'd0) && (((v + 64'd1) & v) == 64'd0);
    endfunction

endpackage

// File: rtl/axis_frame_monitor_if.sv
// AXI4-Stream bundle between the datapath master port and the monitor.
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1; the master holds tdata/tkeep/tuser/tlast stable while tvalid is
// high and tready low, and tready never depends on tvalid.
interface axis_frame_monitor_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tuser,
                    output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tuser,
                    input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), seeded on reset.
module axis_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    output logic [15:0] o_lfsr
);
    logic [15:0] r_lfsr;

    // Shift right every cycle, folding the output bit back into the taps.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign o_lfsr = r_lfsr;
endmodule

// File: rtl/axis_frame_monitor.sv
// AXI4-Stream sink that parses frames, checks them against expected MAC,
// tuser length/port and tkeep legality, and keeps good/bad counters.
module axis_frame_monitor
    import tsn_axis_pkg::*;
#(
    parameter int          AXIS_DATA_WIDTH  = 256,
    parameter int          AXIS_TUSER_WIDTH = 128,
    parameter logic [47:0] EXP_DST_MAC      = 48'h0,
    parameter int          PORT_BIT         = 0,
    parameter int          MIN_LEN          = 60,
    parameter int          MAX_LEN          = 1522,
    parameter int          BACKPRESSURE     = 0,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic               axis_aclk,
    input  logic               axis_resetn,
    axis_frame_monitor_if.slave s_axis,
    input  logic               enable,
    input  logic               clear,
    output logic [31:0]        frame_cnt,
    output logic [31:0]        err_cnt,
    output logic [47:0]        byte_cnt,
    output logic [15:0]        last_len,
    output logic [ERR_W-1:0]   err_flags,
    output mon_state_t         dbg_state
);
    localparam int KW = AXIS_DATA_WIDTH / 8;
    localparam logic [KW-1:0] KEEP_ALL = '1;

    mon_state_t       r_state, w_state_next;
    logic [15:0]      w_lfsr;
    logic             w_tready, w_accept, w_first, w_commit;
    logic [47:0]      w_beat_mac, w_mac_now, r_mac;
    logic [15:0]      w_beat_len, w_acc_base, w_len_now, r_acc;
    logic [16:0]      w_sum;
    logic [15:0]      w_exp_len_now, r_exp_len;
    logic             w_port_now, r_port;
    logic             w_beat_keep_err, w_keep_err_now, r_keep_err;
    logic [ERR_W-1:0] w_flags_now, r_res_flags;
    logic [15:0]      r_res_len;
    logic [31:0]      r_frame_cnt, r_err_cnt;
    logic [47:0]      r_byte_cnt;
    logic [15:0]      r_last_len;
    logic [ERR_W-1:0] r_err_flags;
    logic             w_unused_ok;

    axis_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk    (axis_aclk),
        .i_resetn (axis_resetn),
        .o_lfsr   (w_lfsr)
    );

    // Ready comes only from enable and the registered LFSR, never from tvalid.
    assign w_tready      = enable & ((BACKPRESSURE == 0) | w_lfsr[0]);
    assign s_axis.tready = w_tready;
    assign w_accept      = s_axis.tvalid & w_tready;
    assign w_first       = (r_state != ST_BODY);
    assign w_commit      = (r_state == ST_LAST);

    // Per-beat parse: values as they stand once the current beat is included.
    always_comb begin
        w_beat_mac = {s_axis.tdata[7:0],   s_axis.tdata[15:8],  s_axis.tdata[23:16],
                      s_axis.tdata[31:24], s_axis.tdata[39:32], s_axis.tdata[47:40]};
        w_beat_len = popcount64(64'(s_axis.tkeep));
        w_acc_base = w_first ? 16'd0 : r_acc;
        w_sum      = {1'b0, w_acc_base} + {1'b0, w_beat_len};
        w_len_now  = w_sum[16] ? 16'hFFFF : w_sum[15:0];

        w_beat_keep_err = s_axis.tlast ? ~keep_contig_nz(64'(s_axis.tkeep))
                                       : (s_axis.tkeep != KEEP_ALL);
        w_keep_err_now  = (~w_first & r_keep_err) | w_beat_keep_err;

        w_mac_now     = w_first ? w_beat_mac : r_mac;
        w_exp_len_now = w_first ? s_axis.tuser[LEN_HI:LEN_LO] : r_exp_len;
        w_port_now    = w_first ? s_axis.tuser[DST_PORT_LO + PORT_BIT] : r_port;

        w_flags_now            = '0;
        w_flags_now[ERR_MAC]   = (w_mac_now != EXP_DST_MAC);
        w_flags_now[ERR_LEN]   = (w_len_now != w_exp_len_now);
        w_flags_now[ERR_RANGE] = (w_len_now < 16'(MIN_LEN)) || (w_len_now > 16'(MAX_LEN));
        w_flags_now[ERR_PORT]  = ~w_port_now;
        w_flags_now[ERR_KEEP]  = w_keep_err_now;
    end

    // Frame state register.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a beat accepted in IDLE or LAST opens a new frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_LAST: begin
                w_state_next = ST_IDLE;
                if (w_accept) begin
                    w_state_next = s_axis.tlast ? ST_LAST : ST_BODY;
                end
            end
            ST_BODY: begin
                if (w_accept && s_axis.tlast) begin
                    w_state_next = ST_LAST;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture per-frame fields; results are frozen at tlast so a new frame
    // may start in the LAST cycle without disturbing the pending commit.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_mac       <= '0;
            r_exp_len   <= '0;
            r_port      <= 1'b0;
            r_acc       <= '0;
            r_keep_err  <= 1'b0;
            r_res_len   <= '0;
            r_res_flags <= '0;
        end else if (w_accept) begin
            r_mac      <= w_mac_now;
            r_exp_len  <= w_exp_len_now;
            r_port     <= w_port_now;
            r_acc      <= w_len_now;
            r_keep_err <= w_keep_err_now;
            if (s_axis.tlast) begin
                r_res_len   <= w_len_now;
                r_res_flags <= w_flags_now;
            end
        end
    end

    // Counters and sticky flags; clear overrides a same-cycle commit.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn || clear) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_last_len  <= '0;
            r_err_flags <= '0;
        end else if (w_commit) begin
            r_last_len <= r_res_len;
            if (|r_res_flags) begin
                r_err_cnt   <= r_err_cnt + 32'd1;
                r_err_flags <= r_err_flags | r_res_flags;
            end else begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
                r_byte_cnt  <= r_byte_cnt + {32'd0, r_res_len};
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign byte_cnt  = r_byte_cnt;
    assign last_len  = r_last_len;
    assign err_flags = r_err_flags;
    assign dbg_state = r_state;

    // Payload and metadata bits beyond the parsed fields are not inspected.
    assign w_unused_ok = ^{s_axis.tdata, s_axis.tuser, w_lfsr[15:1]};
endmodule

// File: tb/tb_axis_frame_monitor.sv
// Directed bench for axis_frame_monitor: frames are driven through the
// stream interface, expected counter snapshots are queued as frames are
// issued, and a monitor compares them after every commit cycle.
module tb_axis_frame_monitor;
    import tsn_axis_pkg::*;

    localparam int SNAP_W = 32 + 32 + 48 + 16 + 5;

    logic        axis_aclk = 1'b0;
    logic        axis_resetn;
    logic        enable;
    logic        clear;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;
    logic [47:0] byte_cnt;
    logic [15:0] last_len;
    logic [4:0]  err_flags;
    mon_state_t  dbg_state;

    axis_frame_monitor_if #(.DATA_W(256), .USER_W(128)) s_axis_if ();

    axis_frame_monitor #(
        .AXIS_DATA_WIDTH  (256),
        .AXIS_TUSER_WIDTH (128),
        .EXP_DST_MAC      (48'h0000_0000_0002),
        .PORT_BIT         (0),
        .MIN_LEN          (60),
        .MAX_LEN          (1522),
        .BACKPRESSURE     (1),
        .LFSR_SEED        (16'hACE1)
    ) dut (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .s_axis      (s_axis_if),
        .enable      (enable),
        .clear       (clear),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .byte_cnt    (byte_cnt),
        .last_len    (last_len),
        .err_flags   (err_flags),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 axis_aclk = ~axis_aclk;

    // ---------------- scoreboard state ----------------
    logic [SNAP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_frame;
    logic [31:0] m_err;
    logic [47:0] m_bytes;
    logic [15:0] m_last;
    logic [4:0]  m_flags;

    task automatic check(input string name, input logic [SNAP_W-1:0] act,
                         input logic [SNAP_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {frame_cnt, err_cnt, byte_cnt, last_len, err_flags};
    endfunction

    task automatic model_zero();
        m_frame = '0; m_err = '0; m_bytes = '0; m_last = '0; m_flags = '0;
    endtask

    // Hand-supplied frame length and error bits for the frame about to be sent.
    task automatic expect_frame(input logic [15:0] len, input logic [4:0] flags);
        m_last = len;
        if (flags == 5'd0) begin
            m_frame = m_frame + 32'd1;
            m_bytes = m_bytes + {32'd0, len};
        end else begin
            m_err   = m_err + 32'd1;
            m_flags = m_flags | flags;
        end
        exp_q.push_back({m_frame, m_err, m_bytes, m_last, m_flags});
    endtask

    // Frame whose commit coincides with clear: everything reads back as zero.
    task automatic expect_cleared_commit();
        model_zero();
        exp_q.push_back({m_frame, m_err, m_bytes, m_last, m_flags});
    endtask

    // ---------------- monitor ----------------
    logic prev_last = 1'b0;
    always @(negedge axis_aclk) begin
        if (prev_last) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL commit: got %h with no frame outstanding", dut_snap());
            end else begin
                check("commit", dut_snap(), exp_q.pop_front());
            end
        end
        prev_last = (dbg_state == ST_LAST) && axis_resetn;
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [127:0] u, input logic l);
        bit acc;
        int n;
        s_axis_if.tdata  = d;
        s_axis_if.tkeep  = k;
        s_axis_if.tuser  = u;
        s_axis_if.tlast  = l;
        s_axis_if.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge axis_aclk);
            acc = s_axis_if.tready;
            @(posedge axis_aclk);
            n++;
        end while (!acc && n < 2000);
        #1;
        if (!acc) begin
            n_checks++;
            $display("FAIL handshake: got no tready in %0d cycles, required 1", n);
        end
    endtask

    function automatic logic [127:0] mk_tuser(input logic [15:0] len, input logic port_on);
        logic [127:0] u;
        u = '0;
        u[15:0] = len;
        u[24]   = port_on;
        return u;
    endfunction

    // bad_beat (non-last beat index, or -1) gets bad_keep instead of all-ones.
    task automatic send_frame(input logic [7:0] mac_lo, input logic [15:0] tlen,
                              input logic port_on, input int nbeats,
                              input logic [31:0] last_keep, input int bad_beat,
                              input logic [31:0] bad_keep);
        logic [255:0] d;
        logic [31:0]  k;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            if (b == 0) d[47:0] = {mac_lo, 40'h0};
            if (b == nbeats - 1)  k = last_keep;
            else if (b == bad_beat) k = bad_keep;
            else k = 32'hFFFF_FFFF;
            send_beat(d, k, mk_tuser(tlen, port_on), (b == nbeats - 1));
        end
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] lfsr_m;
    logic        rdy_ok;
    localparam logic [31:0] FULL = 32'hFFFF_FFFF;

    initial begin
        axis_resetn      = 1'b0;
        enable           = 1'b1;
        clear            = 1'b0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = '0;
        s_axis_if.tuser  = '0;
        model_zero();

        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("reset_state", {dut_snap(), 2'(dbg_state)}, '0);

        // Ready pattern straight out of reset follows the seeded LFSR.
        @(posedge axis_aclk); #1;
        axis_resetn = 1'b1;
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 32; i++) begin
            @(negedge axis_aclk);
            check("tready_lfsr", SNAP_W'(s_axis_if.tready), SNAP_W'(lfsr_m[0]));
            lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
        end

        // enable low forces tready low regardless of the LFSR.
        @(posedge axis_aclk); #1;
        enable = 1'b0;
        rdy_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge axis_aclk);
            if (s_axis_if.tready) rdy_ok = 1'b0;
        end
        check("tready_disabled", SNAP_W'(rdy_ok), SNAP_W'(1'b1));
        @(posedge axis_aclk); #1;
        enable = 1'b1;

        // Directed frames: mac byte, tuser len, port, beats, last keep, bad beat.
        expect_frame(16'd64,   5'b00000); send_frame(8'h02, 16'd64,   1'b1, 2,  FULL,          -1, FULL);
        expect_frame(16'd64,   5'b00001); send_frame(8'h03, 16'd64,   1'b1, 2,  FULL,          -1, FULL);
        expect_frame(16'd64,   5'b00010); send_frame(8'h02, 16'd70,   1'b1, 2,  FULL,          -1, FULL);
        expect_frame(16'd1600, 5'b00100); send_frame(8'h02, 16'd1600, 1'b1, 50, FULL,          -1, FULL);
        expect_frame(16'd76,   5'b10000); send_frame(8'h02, 16'd76,   1'b1, 3,  32'h0000_F0FF, -1, FULL);
        expect_frame(16'd95,   5'b10000); send_frame(8'h02, 16'd95,   1'b1, 3,  FULL,          0,  32'h7FFF_FFFF);
        expect_frame(16'd64,   5'b01000); send_frame(8'h02, 16'd64,   1'b0, 2,  FULL,          -1, FULL);
        expect_frame(16'd32,   5'b00100); send_frame(8'h02, 16'd32,   1'b1, 1,  FULL,          -1, FULL);
        expect_frame(16'd60,   5'b00000); send_frame(8'h02, 16'd60,   1'b1, 2,  32'h0FFF_FFFF, -1, FULL);
        expect_frame(16'd1522, 5'b00000); send_frame(8'h02, 16'd1522, 1'b1, 48, 32'h0003_FFFF, -1, FULL);
        expect_frame(16'd1523, 5'b00100); send_frame(8'h02, 16'd1523, 1'b1, 48, 32'h0007_FFFF, -1, FULL);
        expect_frame(16'd32,   5'b10100); send_frame(8'h02, 16'd32,   1'b1, 2,  32'h0000_0000, -1, FULL);
        expect_frame(16'd64,   5'b01011); send_frame(8'h03, 16'd70,   1'b0, 2,  FULL,          -1, FULL);

        // Back-to-back 1518-byte good frames.
        for (int f = 0; f < 20; f++) begin
            expect_frame(16'd1518, 5'b00000);
            send_frame(8'h02, 16'd1518, 1'b1, 48, 32'h0000_3FFF, -1, FULL);
        end

        // clear in the commit cycle: the frame is dropped and counters read 0.
        expect_cleared_commit();
        send_frame(8'h02, 16'd64, 1'b1, 2, FULL, -1, FULL);
        clear = 1'b1;
        @(posedge axis_aclk); #1;
        clear = 1'b0;
        expect_frame(16'd64, 5'b00000);
        send_frame(8'h02, 16'd64, 1'b1, 2, FULL, -1, FULL);
        repeat (4) @(posedge axis_aclk);
        #1;

        // Reset mid-frame: counters drop to 0, the tail becomes its own frame.
        send_beat({$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), 8'h02, 24'h0},
                  FULL, mk_tuser(16'd64, 1'b1), 1'b0);
        s_axis_if.tvalid = 1'b0;
        axis_resetn = 1'b0;
        @(posedge axis_aclk); #1;
        axis_resetn = 1'b1;
        @(negedge axis_aclk);
        check("mid_frame_reset", {dut_snap(), 2'(dbg_state)}, '0);
        model_zero();
        @(posedge axis_aclk); #1;
        expect_frame(16'd32, 5'b00111);
        send_beat('0, FULL, mk_tuser(16'd64, 1'b1), 1'b1);
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        expect_frame(16'd64, 5'b00000);
        send_frame(8'h02, 16'd64, 1'b1, 2, FULL, -1, FULL);

        // Drain and confirm every issued frame was committed exactly once.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge axis_aclk);
        repeat (4) @(negedge axis_aclk);
        check("queue_drained", SNAP_W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, required end before time limit");
        $fatal(1);
    end
endmodule
